// File: rtl/cpu_trace_pkg.sv
// Shared encodings for the CPU trace buffer: entry kinds, run status and the
// 46-bit entry layout {kind, pc, payload, nzcv}.
package cpu_trace_pkg;

  localparam logic [1:0] KIND_FLAG  = 2'b00;
  localparam logic [1:0] KIND_FETCH = 2'b01;
  localparam logic [1:0] KIND_WB    = 2'b10;
  localparam logic [1:0] KIND_BOTH  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_ERR     = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  localparam int ENTRY_W     = 46;
  localparam int PC_FIELD_W  = 8;
  localparam int NZCV_LSB    = 0;
  localparam int PAYLOAD_LSB = 4;
  localparam int PC_LSB      = 36;
  localparam int KIND_LSB    = 44;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [1:0]            kind,
    input logic [PC_FIELD_W-1:0] pc,
    input logic [31:0]           payload,
    input logic [3:0]            nzcv
  );
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[KIND_LSB +: 2]           = kind;
    e[PC_LSB +: PC_FIELD_W]    = pc;
    e[PAYLOAD_LSB +: 32]       = payload;
    e[NZCV_LSB +: 4]           = nzcv;
    return e;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO; head_data shows the oldest entry (zero when
// empty). A push into a full FIFO is accepted only when a pop frees the slot.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 46,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CP,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CP) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full, wr_ptr equals rd_ptr; the head is read before this edge overwrites it.
  always_ff @(posedge CP) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Commit-event tracer for CPU_Top: encodes strobes into entries, buffers them in
// a FWFT FIFO and tracks run status. Define TRACE_FLAGS_EN to log flag changes.
//
// state      | meaning
// ST_RUN     | capturing events, counting cycles, watching for a stall
// ST_DONE    | CPU halted normally; capture and cycles frozen
// ST_ERR     | CPU halted on error; capture and cycles frozen
// ST_TIMEOUT | no fetch for TIMEOUT cycles; capture and cycles frozen
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1500,
  parameter int PC_W    = 8
) (
  input  logic                         CP,
  input  logic                         reset,
  input  logic                         writePC,
  input  logic                         writeIR,
  input  logic                         writeReg,
  input  logic [31:0]                  IR,
  input  logic [31:0]                  F,
  input  logic [PC_W-1:0]              PC,
  input  logic [3:0]                   nzcv,
  input  logic                         done,
  input  logic                         err,
  input  logic                         rd_en,
  output logic                         rd_valid,
  output logic [ENTRY_W-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic [7:0]                   dropped,
  output logic [1:0]                   status,
  output logic [31:0]                  cycles
);

  localparam int STALL_W = $clog2(TIMEOUT);

  status_e              status_q, status_d;
  logic [STALL_W-1:0]   stall_left_q, stall_left_d;
  logic [31:0]          cycles_q, cycles_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           dropped_q, dropped_d;

  logic                 evt_push;
  logic [1:0]           evt_kind;
  logic [31:0]          evt_payload;
  logic                 flag_change;
  logic [3:0]           nz_field;
  logic                 fifo_full, fifo_empty, fifo_pop;
  logic [ENTRY_W-1:0]   evt_entry;

  // writePC only moves the PC; it never produces an entry on its own.
  logic unused_strobe;
  assign unused_strobe = writePC;

`ifdef TRACE_FLAGS_EN
  logic [3:0] last_nzcv_q, last_nzcv_d;

  assign flag_change = (nzcv != last_nzcv_q);
  assign nz_field    = nzcv;

  always_comb begin
    last_nzcv_d = last_nzcv_q;
    if (status_q == ST_RUN) last_nzcv_d = nzcv;
  end

  always_ff @(posedge CP) begin
    if (reset) last_nzcv_q <= '0;
    else       last_nzcv_q <= last_nzcv_d;
  end
`else
  logic unused_nzcv;
  assign unused_nzcv = ^nzcv;
  assign flag_change = 1'b0;
  assign nz_field    = 4'h0;
`endif

  assign fifo_pop  = rd_en && !fifo_empty;
  assign evt_entry = pack_entry(evt_kind, PC_FIELD_W'(PC), evt_payload, nz_field);

  always_comb begin
    status_d     = status_q;
    stall_left_d = stall_left_q;
    cycles_d     = cycles_q;
    overflow_d   = overflow_q;
    dropped_d    = dropped_q;
    evt_push     = 1'b0;
    evt_kind     = KIND_FLAG;
    evt_payload  = '0;

    if (status_q == ST_RUN) begin
      cycles_d     = cycles_q + 32'd1;
      stall_left_d = writeIR ? STALL_W'(TIMEOUT - 1) : stall_left_q - 1'b1;

      if (writeIR && writeReg) begin
        evt_push    = 1'b1;
        evt_kind    = KIND_BOTH;
        evt_payload = F;
      end else if (writeIR) begin
        evt_push    = 1'b1;
        evt_kind    = KIND_FETCH;
        evt_payload = IR;
      end else if (writeReg) begin
        evt_push    = 1'b1;
        evt_kind    = KIND_WB;
        evt_payload = F;
      end else if (flag_change) begin
        evt_push    = 1'b1;
        evt_kind    = KIND_FLAG;
      end

      if (err)                                   status_d = ST_ERR;
      else if (done)                             status_d = ST_DONE;
      else if (!writeIR && stall_left_q == '0)   status_d = ST_TIMEOUT;
    end

    if (evt_push && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
      if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
    end
  end

  always_ff @(posedge CP) begin
    if (reset) begin
      status_q     <= ST_RUN;
      stall_left_q <= STALL_W'(TIMEOUT - 1);
      cycles_q     <= '0;
      overflow_q   <= 1'b0;
      dropped_q    <= '0;
    end else begin
      status_q     <= status_d;
      stall_left_q <= stall_left_d;
      cycles_q     <= cycles_d;
      overflow_q   <= overflow_d;
      dropped_q    <= dropped_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .CP        (CP),
    .reset     (reset),
    .push      (evt_push),
    .push_data (evt_entry),
    .pop       (fifo_pop),
    .head_data (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign rd_valid = !fifo_empty;
  assign overflow = overflow_q;
  assign dropped  = dropped_q;
  assign status   = status_q;
  assign cycles   = cycles_q;

endmodule
